// File: rtl/id_pkg.sv
// Shared decode constants, control bundle and condition evaluation for the ID stage.
package id_pkg;

    // Instruction class held in instruction[27:26]
    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // ARM data-processing opcodes that the decoder recognises
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // ALU commands understood by EXE
    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic       b;
        logic       s;
        logic       imm;
    } ctrl_t;

    // Data-processing opcode to ALU command; unlisted opcodes become NOP
    function automatic logic [3:0] op_to_cmd(input logic [3:0] opcode);
        logic [3:0] cmd;
        case (opcode)
            OP_MOV:         cmd = CMD_MOV;
            OP_MVN:         cmd = CMD_MVN;
            OP_ADD:         cmd = CMD_ADD;
            OP_ADC:         cmd = CMD_ADC;
            OP_SUB, OP_CMP: cmd = CMD_SUB;
            OP_SBC:         cmd = CMD_SBC;
            OP_AND, OP_TST: cmd = CMD_AND;
            OP_ORR:         cmd = CMD_ORR;
            OP_EOR:         cmd = CMD_EOR;
            default:        cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

    // Evaluate a condition field against NZCV; the reserved code NV never passes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, ok;
        {n, z, c, v} = nzcv;
        case (cond_e'(cond))
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CS: ok = c;
            COND_CC: ok = !c;
            COND_MI: ok = n;
            COND_PL: ok = !n;
            COND_VS: ok = v;
            COND_VC: ok = !v;
            COND_HI: ok = c && !z;
            COND_LS: ok = !c || z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = !z && (n == v);
            COND_LE: ok = z || (n != v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two combinational read ports and write-through from WB.
module id_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Architectural state: cleared on reset, written by WB at the clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every entry is reset because software may read a register before writing it;
            // this forces flops rather than a RAM macro, which is fine at this size.
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state uses <= so all flops sample pre-edge values together.
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_dest] <= wb_value;
        end
    end

    // A write landing this cycle is visible to the decode reading it now
    assign rd_data1 = (wb_en && wb_dest == rd_addr1) ? wb_value : regs[rd_addr1];
    assign rd_data2 = (wb_en && wb_dest == rd_addr2) ? wb_value : regs[rd_addr2];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: field decode, condition check, RAW hazard detection and ID/EXE register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int FWD_EN   = 0,
    parameter int IMM_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        status,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic              mem_wb_en,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic              branch_taken,
    output logic              freeze,
    output logic              flush,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_val_rn,
    output logic [DATA_W-1:0] id_val_rm,
    output logic [ADDR_W-1:0] id_src1,
    output logic [ADDR_W-1:0] id_src2,
    output logic [ADDR_W-1:0] id_dest,
    output logic              id_wb_en,
    output logic              id_mem_read,
    output logic              id_mem_write,
    output logic              id_b,
    output logic              id_s,
    output logic              id_imm,
    output logic [3:0]        id_exe_cmd,
    output logic [11:0]       id_shift_operand,
    output logic [IMM_W-1:0]  id_signed_imm
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ADDR_W-1:0] dest;
        ctrl_t             ctrl;
        logic [11:0]       shift_operand;
        logic [IMM_W-1:0]  signed_imm;
    } id_exe_t;

    logic [1:0]        mode;
    logic              imm_bit;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [ADDR_W-1:0] rn, rd, rm, src1, src2;
    logic [DATA_W-1:0] val_rn, val_rm;
    logic              cond_ok, uses_src1, uses_src2;
    logic              exe_hit, mem_hit, hazard_stall, hazard_fwd, hazard;
    ctrl_t             dec, ctrl;
    id_exe_t           id_d, id_q;

    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_bit   = instruction[20];
    assign rn      = instruction[16 +: ADDR_W];
    assign rd      = instruction[12 +: ADDR_W];
    assign rm      = instruction[0 +: ADDR_W];
    assign cond_ok = cond_check(instruction[31:28], status);

    // Raw control decode by instruction class
    always_comb begin
        // NOTE: the default assignment first means every path drives dec, so no latch is inferred.
        dec = '0;
        case (mode)
            MODE_ALU: begin
                dec.exe_cmd = op_to_cmd(opcode);
                dec.wb_en   = (opcode != OP_CMP) && (opcode != OP_TST);
                dec.s       = s_bit;
                dec.imm     = imm_bit;
            end
            MODE_MEM: begin
                dec.exe_cmd   = CMD_ADD;
                dec.mem_read  = s_bit;
                dec.wb_en     = s_bit;
                dec.mem_write = !s_bit;
                dec.imm       = imm_bit;
            end
            MODE_BR:  dec.b = 1'b1;
            default:  ;
        endcase
    end

    // A failed condition kills side effects but the instruction still flows
    always_comb begin
        ctrl = dec;
        if (!cond_ok) begin
            ctrl.wb_en     = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.b         = 1'b0;
            ctrl.s         = 1'b0;
        end
    end

    // Stores read the data register through the second port
    assign src1      = rn;
    assign src2      = dec.mem_write ? rd : rm;
    assign uses_src2 = dec.mem_write || (mode == MODE_ALU && !imm_bit);
    assign uses_src1 = !((mode == MODE_ALU && (opcode == OP_MOV || opcode == OP_MVN)) || dec.b);

    assign exe_hit      = (uses_src1 && src1 == exe_dest) || (uses_src2 && src2 == exe_dest);
    assign mem_hit      = (uses_src1 && src1 == mem_dest) || (uses_src2 && src2 == mem_dest);
    assign hazard_stall = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
    assign hazard_fwd   = exe_mem_read && exe_hit;
    assign hazard       = instr_valid && cond_ok && ((FWD_EN != 0) ? hazard_fwd : hazard_stall);

    // A flush discards the instruction anyway, so stalling it would only waste a cycle
    assign freeze = hazard && !branch_taken;
    assign flush  = branch_taken;

    id_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (val_rn),
        .rd_data2 (val_rm)
    );

    // Gather the decoded instruction for the ID/EXE register
    always_comb begin
        id_d               = '0;
        id_d.valid         = instr_valid;
        id_d.pc            = pc;
        id_d.val_rn        = val_rn;
        id_d.val_rm        = val_rm;
        id_d.src1          = src1;
        id_d.src2          = src2;
        id_d.dest          = rd;
        id_d.ctrl          = ctrl;
        id_d.shift_operand = instruction[11:0];
        id_d.signed_imm    = instruction[IMM_W-1:0];
    end

    // ID/EXE register: flush and stall both insert an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= '0;
        end else if (branch_taken || freeze) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    assign id_valid         = id_q.valid;
    assign id_pc            = id_q.pc;
    assign id_val_rn        = id_q.val_rn;
    assign id_val_rm        = id_q.val_rm;
    assign id_src1          = id_q.src1;
    assign id_src2          = id_q.src2;
    assign id_dest          = id_q.dest;
    assign id_wb_en         = id_q.ctrl.wb_en;
    assign id_mem_read      = id_q.ctrl.mem_read;
    assign id_mem_write     = id_q.ctrl.mem_write;
    assign id_b             = id_q.ctrl.b;
    assign id_s             = id_q.ctrl.s;
    assign id_imm           = id_q.ctrl.imm;
    assign id_exe_cmd       = id_q.ctrl.exe_cmd;
    assign id_shift_operand = id_q.shift_operand;
    assign id_signed_imm    = id_q.signed_imm;

endmodule
